// File: rtl/eqed_pkg.sv
// Shared types and constants for the E-QED injection/capture harness.
package eqed_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} eqed_state_t;

  localparam int         MISR_SEED = 1;
  localparam logic [5:0] DEF_POLY  = 6'h03;

endpackage

// File: rtl/eqed_misr.sv
// Multiple-input signature register: shift-left Galois feedback with zero-extended data folded in.
module eqed_misr
  import eqed_pkg::*;
#(
  parameter int             W    = 6,
  parameter int             DW   = 2,
  parameter logic [W-1:0]   POLY = W'(DEF_POLY)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [W-1:0]  sig
);

  logic [W-1:0] sig_q;
  logic [W-1:0] sig_d;
  logic [W-1:0] d_ext;

  always_comb begin
    d_ext         = '0;
    d_ext[DW-1:0] = d;
    sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ d_ext;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= W'(MISR_SEED);
    end else if (clear) begin
      sig_q <= W'(MISR_SEED);
    end else if (en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/eqed_inject_ctrl.sv
// E-QED harness controller: run FSM, cycle counter, one-shot single-FF flip decoder and
// input/output signature capture with on-chip compare against expected signatures.
module eqed_inject_ctrl
  import eqed_pkg::*;
#(
  parameter int                NUM_FF = 8,
  parameter int                SEL_W  = 4,
  parameter int                CNT_W  = 10,
  parameter int                IN_W   = 2,
  parameter int                OUT_W  = 3,
  parameter int                MISR_W = 6,
  parameter logic [MISR_W-1:0] POLY   = MISR_W'(DEF_POLY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  inj_sel,
  input  logic [CNT_W-1:0]  inj_cycle,
  input  logic [CNT_W-1:0]  window,
  input  logic [MISR_W-1:0] exp_in_sig,
  input  logic [MISR_W-1:0] exp_out_sig,
  input  logic [IN_W-1:0]   in_data,
  input  logic [OUT_W-1:0]  out_data,
  output logic [NUM_FF-1:0] inj_onehot,
  output logic              injected,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [MISR_W-1:0] in_sig,
  output logic [MISR_W-1:0] out_sig
);

  localparam logic [SEL_W-1:0] NUM_FF_SEL = SEL_W'(NUM_FF);

  eqed_state_t         state_q, state_d;
  logic [CNT_W-1:0]    cycle_q;
  logic                injected_q;
  logic [SEL_W-1:0]    sel_q;
  logic [CNT_W-1:0]    icyc_q;
  logic [CNT_W-1:0]    win_q;
  logic [MISR_W-1:0]   exp_in_q;
  logic [MISR_W-1:0]   exp_out_q;
  logic                load;
  logic                run_en;

  // Start is only honoured outside RUN, so a start coinciding with the final edge waits for DONE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (window == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cycle_q == win_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign run_en = (state_q == RUN);

  always_comb begin
    inj_onehot = '0;
    if (run_en && !injected_q && (cycle_q == icyc_q) && (sel_q < NUM_FF_SEL)) begin
      inj_onehot = NUM_FF'(1) << sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cycle_q    <= CNT_W'(1);
      injected_q <= 1'b0;
      sel_q      <= '0;
      icyc_q     <= '0;
      win_q      <= '0;
      exp_in_q   <= '0;
      exp_out_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        cycle_q    <= CNT_W'(1);
        injected_q <= 1'b0;
        sel_q      <= inj_sel;
        icyc_q     <= inj_cycle;
        win_q      <= window;
        exp_in_q   <= exp_in_sig;
        exp_out_q  <= exp_out_sig;
      end else if (run_en) begin
        if (cycle_q != '1) cycle_q <= cycle_q + CNT_W'(1);
        injected_q <= injected_q | (|inj_onehot);
      end
    end
  end

  eqed_misr #(.W(MISR_W), .DW(IN_W), .POLY(POLY)) u_in_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (load),
    .en    (run_en),
    .d     (in_data),
    .sig   (in_sig)
  );

  eqed_misr #(.W(MISR_W), .DW(OUT_W), .POLY(POLY)) u_out_misr (
    .clk   (clk),
    .rst   (rst),
    .clear (load),
    .en    (run_en),
    .d     (out_data),
    .sig   (out_sig)
  );

  assign injected    = injected_q;
  assign busy        = run_en;
  assign done        = (state_q == DONE);
  assign match       = done && (in_sig == exp_in_q) && (out_sig == exp_out_q);
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_eqed_inject_ctrl.sv
// Directed bench for eqed_inject_ctrl: runs, injection, match, boundaries, abort and start-in-RUN.
module tb_eqed_inject_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] inj_sel;
  logic [9:0] inj_cycle;
  logic [9:0] window;
  logic [5:0] exp_in_sig;
  logic [5:0] exp_out_sig;
  logic [1:0] in_data;
  logic [2:0] out_data;
  logic [7:0] inj_onehot;
  logic       injected;
  logic       busy;
  logic       done;
  logic       match;
  logic [9:0] cycle_count;
  logic [5:0] in_sig;
  logic [5:0] out_sig;

  int errors = 0;
  int checks = 0;

  eqed_inject_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .inj_sel     (inj_sel),
    .inj_cycle   (inj_cycle),
    .window      (window),
    .exp_in_sig  (exp_in_sig),
    .exp_out_sig (exp_out_sig),
    .in_data     (in_data),
    .out_data    (out_data),
    .inj_onehot  (inj_onehot),
    .injected    (injected),
    .busy        (busy),
    .done        (done),
    .match       (match),
    .cycle_count (cycle_count),
    .in_sig      (in_sig),
    .out_sig     (out_sig)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a start pulse; on return the first RUN cycle (cycle_count==1) is visible.
  task automatic launch(input logic [3:0] sel, input logic [9:0] icyc, input logic [9:0] win,
                        input logic [5:0] ein, input logic [5:0] eout);
    inj_sel     = sel;
    inj_cycle   = icyc;
    window      = win;
    exp_in_sig  = ein;
    exp_out_sig = eout;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; inj_sel = '0; inj_cycle = '0; window = '0;
    exp_in_sig = '0; exp_out_sig = '0; in_data = '0; out_data = '0;
    #12;
    checks++;
    if ({busy, done, match, injected} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, match, injected});
    end
    checks++;
    if ({cycle_count, in_sig, out_sig, inj_onehot} !== {10'd1, 6'h01, 6'h01, 8'h00}) begin
      errors++; $display("FAIL reset_values: cnt=%0d in=%h out=%h oh=%h want 1/01/01/00",
                         cycle_count, in_sig, out_sig, inj_onehot);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic test_no_flip();
    launch(4'd8, 10'd2, 10'd5, 6'h00, 6'h00);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if ({busy, done, cycle_count, inj_onehot} !== {1'b1, 1'b0, 10'(k), 8'h00}) begin
        errors++; $display("FAIL noflip_run%0d: busy=%b done=%b cnt=%0d oh=%h want 1/0/%0d/00",
                           k, busy, done, cycle_count, inj_onehot, k);
      end
      tick();
    end
    checks++;
    if ({done, busy, injected, in_sig, out_sig} !== {1'b1, 1'b0, 1'b0, 6'h20, 6'h20}) begin
      errors++; $display("FAIL noflip_done: done=%b busy=%b inj=%b in=%h out=%h want 1/0/0/20/20",
                         done, busy, injected, in_sig, out_sig);
    end
    checks++;
    if (match !== 1'b0) begin
      errors++; $display("FAIL noflip_match: got %b want 0", match);
    end
  endtask

  task automatic test_injection();
    launch(4'd3, 10'd2, 10'd5, 6'h20, 6'h20);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (inj_onehot !== ((k == 2) ? 8'h08 : 8'h00)) begin
        errors++; $display("FAIL inj_onehot_c%0d: got %h want %h", k, inj_onehot, (k == 2) ? 8'h08 : 8'h00);
      end
      checks++;
      if (injected !== (k >= 3)) begin
        errors++; $display("FAIL inj_flag_c%0d: got %b want %b", k, injected, k >= 3);
      end
      tick();
    end
    checks++;
    if ({done, injected, inj_onehot} !== {1'b1, 1'b1, 8'h00}) begin
      errors++; $display("FAIL inj_done: done=%b inj=%b oh=%h want 1/1/00", done, injected, inj_onehot);
    end
  endtask

  task automatic test_match();
    launch(4'd8, 10'd0, 10'd5, 6'h20, 6'h20);
    checks++;
    if (match !== 1'b0) begin
      errors++; $display("FAIL match_in_run: got %b want 0", match);
    end
    repeat (5) tick();
    checks++;
    if ({done, match} !== 2'b11) begin
      errors++; $display("FAIL match_hit: done=%b match=%b want 1/1", done, match);
    end
    launch(4'd8, 10'd0, 10'd5, 6'h20, 6'h21);
    repeat (5) tick();
    checks++;
    if ({done, match} !== 2'b10) begin
      errors++; $display("FAIL match_miss: done=%b match=%b want 1/0", done, match);
    end
  endtask

  task automatic test_data_compaction();
    in_data = 2'd1; out_data = 3'd5;
    launch(4'd15, 10'd0, 10'd3, 6'h0F, 6'h13);
    repeat (3) tick();
    in_data = 2'd0; out_data = 3'd0;
    checks++;
    if ({in_sig, out_sig} !== {6'h0F, 6'h13}) begin
      errors++; $display("FAIL data_sigs: in=%h out=%h want 0f/13", in_sig, out_sig);
    end
    checks++;
    if (match !== 1'b1) begin
      errors++; $display("FAIL data_match: got %b want 1", match);
    end
    launch(4'd8, 10'd0, 10'd7, 6'h00, 6'h00);
    repeat (7) tick();
    checks++;
    if ({done, in_sig, out_sig} !== {1'b1, 6'h06, 6'h06}) begin
      errors++; $display("FAIL feedback_sigs: done=%b in=%h out=%h want 1/06/06", done, in_sig, out_sig);
    end
  endtask

  task automatic test_boundaries();
    launch(4'd2, 10'd1, 10'd0, 6'h01, 6'h01);
    checks++;
    if ({done, busy, in_sig, out_sig, inj_onehot} !== {1'b1, 1'b0, 6'h01, 6'h01, 8'h00}) begin
      errors++; $display("FAIL window0: done=%b busy=%b in=%h out=%h oh=%h want 1/0/01/01/00",
                         done, busy, in_sig, out_sig, inj_onehot);
    end
    checks++;
    if (match !== 1'b1) begin
      errors++; $display("FAIL window0_match: got %b want 1", match);
    end
    launch(4'd3, 10'd7, 10'd5, 6'h00, 6'h00);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (inj_onehot !== 8'h00) begin
        errors++; $display("FAIL late_cycle_c%0d: oh=%h want 00", k, inj_onehot);
      end
      tick();
    end
    checks++;
    if ({done, injected} !== 2'b10) begin
      errors++; $display("FAIL late_cycle_done: done=%b inj=%b want 1/0", done, injected);
    end
  endtask

  task automatic test_abort();
    launch(4'd3, 10'd3, 10'd5, 6'h00, 6'h00);
    tick();
    tick();
    checks++;
    if ({cycle_count, inj_onehot} !== {10'd3, 8'h08}) begin
      errors++; $display("FAIL abort_pre: cnt=%0d oh=%h want 3/08", cycle_count, inj_onehot);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, done, match, injected, inj_onehot} !== {4'b0000, 8'h00}) begin
      errors++; $display("FAIL abort_flags: busy=%b done=%b match=%b inj=%b oh=%h want 0/0/0/0/00",
                         busy, done, match, injected, inj_onehot);
    end
    checks++;
    if ({cycle_count, in_sig, out_sig} !== {10'd1, 6'h01, 6'h01}) begin
      errors++; $display("FAIL abort_values: cnt=%0d in=%h out=%h want 1/01/01", cycle_count, in_sig, out_sig);
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL abort_idle: busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    launch(4'd8, 10'd0, 10'd5, 6'h20, 6'h20);
    tick();
    window = 10'd0; inj_sel = 4'd1; inj_cycle = 10'd4; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, cycle_count} !== {1'b1, 10'd3}) begin
      errors++; $display("FAIL start_in_run: busy=%b cnt=%0d want 1/3", busy, cycle_count);
    end
    tick();
    checks++;
    if (inj_onehot !== 8'h00) begin
      errors++; $display("FAIL start_in_run_latch: oh=%h want 00", inj_onehot);
    end
    // Start held across the final RUN edge must not restart until DONE is visible.
    start = 1'b1;
    tick();
    checks++;
    if ({busy, done} !== 2'b10) begin
      errors++; $display("FAIL final_edge_pre: busy=%b done=%b want 1/0", busy, done);
    end
    tick();
    start = 1'b0;
    checks++;
    if ({done, match, in_sig} !== {1'b1, 1'b1, 6'h20}) begin
      errors++; $display("FAIL final_edge_done: done=%b match=%b in=%h want 1/1/20", done, match, in_sig);
    end
  endtask

  initial begin
    test_reset();
    test_no_flip();
    test_injection();
    test_match();
    test_data_compaction();
    test_boundaries();
    test_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
